mult_trunc_pipe: RTL and testbench

MULT_TRUNC_PIPE -- requirements
Module: mult_trunc_pipe

---
 rtl/mult_trunc_pipe.sv | 160 ++++++++++++++++
 tb/tb_mult_trunc_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_trunc_pipe.sv
// Two-stage pipelined unsigned multiplier with optional truncation of the low product columns.
// Stage 1 masks partial products and Wallace-reduces them to two rows; stage 2 adds them with a prefix adder.
module mult_trunc_pipe #(
    parameter int WIDTH = 7,
    parameter int TRUNC = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_exact,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_prod,
    output logic               out_exact
);
    localparam int PW     = 2 * WIDTH;
    localparam int HMAX   = WIDTH + 3;
    localparam int NSTAGE = 10;
    localparam int LVLS   = $clog2(PW);

    logic s2_adv, s1_adv;
    logic s1_valid_q, s1_valid_d;
    logic s1_exact_q, s1_exact_d;
    logic [PW-1:0] s1_row0_q, s1_row0_d;
    logic [PW-1:0] s1_row1_q, s1_row1_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_exact_q, s2_exact_d;
    logic [PW-1:0] s2_prod_q, s2_prod_d;

    logic [PW-1:0][HMAX-1:0] col_bits, nxt_bits;
    int col_h [PW];
    int nxt_h [PW];
    logic busy;
    logic [PW-1:0] row0, row1;

    logic [PW-1:0] gen, prop, grp_g, grp_p, sum;

    // Column heights depend only on parameters, so every loop below folds to fixed adder wiring.
    always_comb begin
        col_bits = '0;
        nxt_bits = '0;
        busy     = 1'b0;
        for (int c = 0; c < PW; c++) begin
            col_h[c] = 0;
            nxt_h[c] = 0;
        end
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                col_bits[i+j][col_h[i+j]] = in_a[i] & in_b[j] & (in_exact | (i + j >= TRUNC));
                col_h[i+j] = col_h[i+j] + 1;
            end
        end
        for (int s = 0; s < NSTAGE; s++) begin
            busy = 1'b0;
            for (int c = 0; c < PW; c++) begin
                if (col_h[c] > 2) busy = 1'b1;
            end
            if (busy) begin
                nxt_bits = '0;
                for (int c = 0; c < PW; c++) nxt_h[c] = 0;
                for (int c = 0; c < PW; c++) begin
                    for (int g = 0; g <= HMAX / 3; g++) begin
                        // Triples become full adders, a leftover pair a half adder, a single bit passes.
                        if (3 * g + 3 <= col_h[c]) begin
                            nxt_bits[c][nxt_h[c]] = col_bits[c][3*g] ^ col_bits[c][3*g+1] ^ col_bits[c][3*g+2];
                            nxt_h[c] = nxt_h[c] + 1;
                            if (c + 1 < PW) begin
                                nxt_bits[c+1][nxt_h[c+1]] = (col_bits[c][3*g] & col_bits[c][3*g+1])
                                                          | (col_bits[c][3*g] & col_bits[c][3*g+2])
                                                          | (col_bits[c][3*g+1] & col_bits[c][3*g+2]);
                                nxt_h[c+1] = nxt_h[c+1] + 1;
                            end
                        end else if (3 * g + 2 == col_h[c]) begin
                            nxt_bits[c][nxt_h[c]] = col_bits[c][3*g] ^ col_bits[c][3*g+1];
                            nxt_h[c] = nxt_h[c] + 1;
                            if (c + 1 < PW) begin
                                nxt_bits[c+1][nxt_h[c+1]] = col_bits[c][3*g] & col_bits[c][3*g+1];
                                nxt_h[c+1] = nxt_h[c+1] + 1;
                            end
                        end else if (3 * g + 1 == col_h[c]) begin
                            nxt_bits[c][nxt_h[c]] = col_bits[c][3*g];
                            nxt_h[c] = nxt_h[c] + 1;
                        end
                    end
                end
                col_bits = nxt_bits;
                for (int c = 0; c < PW; c++) col_h[c] = nxt_h[c];
            end
        end
        for (int c = 0; c < PW; c++) begin
            row0[c] = col_bits[c][0];
            row1[c] = col_bits[c][1];
        end
    end

    // Kogge-Stone prefix over generate/propagate; carry-in is zero.
    always_comb begin
        gen   = s1_row0_q & s1_row1_q;
        prop  = s1_row0_q ^ s1_row1_q;
        grp_g = gen;
        grp_p = prop;
        for (int l = 0; l < LVLS; l++) begin
            for (int i = PW - 1; i >= (1 << l); i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-(1<<l)]);
                grp_p[i] = grp_p[i] & grp_p[i-(1<<l)];
            end
        end
        sum = prop ^ {grp_g[PW-2:0], 1'b0};
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_exact_d = s1_exact_q;
        s1_row0_d  = s1_row0_q;
        s1_row1_d  = s1_row1_q;
        if (s1_adv && in_valid) begin
            s1_exact_d = in_exact;
            s1_row0_d  = row0;
            s1_row1_d  = row1;
        end
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_exact_d = s2_exact_q;
        s2_prod_d  = s2_prod_q;
        if (s2_adv && s1_valid_q) begin
            s2_exact_d = s1_exact_q;
            s2_prod_d  = sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_exact_q <= 1'b0;
            s1_row0_q  <= '0;
            s1_row1_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_exact_q <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_exact_q <= s1_exact_d;
            s1_row0_q  <= s1_row0_d;
            s1_row1_q  <= s1_row1_d;
            s2_valid_q <= s2_valid_d;
            s2_exact_q <= s2_exact_d;
            s2_prod_q  <= s2_prod_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_prod  = s2_prod_q;
    assign out_exact = s2_exact_q;

endmodule

// File: tb/tb_mult_trunc_pipe.sv
// Directed and randomized scoreboard bench for mult_trunc_pipe, including a parameter sweep.
module tb_mult_trunc_pipe;

    typedef struct {
        logic [63:0] prod;
        logic        ex;
        int          cyc;
        bit          lat_chk;
    } beat_t;

    localparam int SW_W [4] = '{16, 2, 7, 16};
    localparam int SW_T [4] = '{16, 3, 0, 1};

    logic clk, rst;
    logic in_valid, in_ready, in_exact, out_valid, out_ready, out_exact;
    logic [6:0] in_a, in_b;
    logic [13:0] out_prod;

    logic sw_valid, sw_ordy, sw_ex;
    logic [15:0] sw_a, sw_b;
    int sw_sel;
    logic [3:0] sw_ivld, sw_irdy, sw_ovld, sw_oex;
    logic [31:0] p0, p3;
    logic [3:0] p1;
    logic [13:0] p2;
    logic [31:0] sw_prod [4];

    beat_t sb[$];
    beat_t sw_sb[$];
    int errors, checks, cyc;
    bit expect_lat2;
    logic [6:0] ra, rb;
    logic re;
    int start_cyc;

    mult_trunc_pipe #(.WIDTH(7), .TRUNC(5)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_exact(in_exact), .out_valid(out_valid),
        .out_ready(out_ready), .out_prod(out_prod), .out_exact(out_exact));

    mult_trunc_pipe #(.WIDTH(16), .TRUNC(16)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(sw_ivld[0]), .in_ready(sw_irdy[0]),
        .in_a(sw_a), .in_b(sw_b), .in_exact(sw_ex), .out_valid(sw_ovld[0]),
        .out_ready(sw_ordy), .out_prod(p0), .out_exact(sw_oex[0]));

    mult_trunc_pipe #(.WIDTH(2), .TRUNC(3)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(sw_ivld[1]), .in_ready(sw_irdy[1]),
        .in_a(sw_a[1:0]), .in_b(sw_b[1:0]), .in_exact(sw_ex), .out_valid(sw_ovld[1]),
        .out_ready(sw_ordy), .out_prod(p1), .out_exact(sw_oex[1]));

    mult_trunc_pipe #(.WIDTH(7), .TRUNC(0)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(sw_ivld[2]), .in_ready(sw_irdy[2]),
        .in_a(sw_a[6:0]), .in_b(sw_b[6:0]), .in_exact(sw_ex), .out_valid(sw_ovld[2]),
        .out_ready(sw_ordy), .out_prod(p2), .out_exact(sw_oex[2]));

    mult_trunc_pipe #(.WIDTH(16), .TRUNC(1)) u_s3 (
        .clk(clk), .rst(rst), .in_valid(sw_ivld[3]), .in_ready(sw_irdy[3]),
        .in_a(sw_a), .in_b(sw_b), .in_exact(sw_ex), .out_valid(sw_ovld[3]),
        .out_ready(sw_ordy), .out_prod(p3), .out_exact(sw_oex[3]));

    always_comb begin
        for (int k = 0; k < 4; k++) sw_ivld[k] = sw_valid && (sw_sel == k);
        sw_prod[0] = p0;
        sw_prod[1] = {28'd0, p1};
        sw_prod[2] = {18'd0, p2};
        sw_prod[3] = p3;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: direct sum of the surviving partial products.
    function automatic logic [63:0] model(input int w, input int t, input logic [63:0] a,
                                          input logic [63:0] b, input logic ex);
        logic [63:0] acc;
        acc = '0;
        for (int i = 0; i < w; i++)
            for (int j = 0; j < w; j++)
                if (a[i] && b[j] && (ex || (i + j >= t))) acc = acc + (64'd1 << (i + j));
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at the drive point (just after a rising edge); returns at the next drive point.
    task automatic applyStimulus(input logic [6:0] a, input logic [6:0] b, input logic ex,
                                 input logic [63:0] exp);
        int waited;
        beat_t e;
        waited = 0;
        in_a = a;
        in_b = b;
        in_exact = ex;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready) begin
            e.prod = exp;
            e.ex = ex;
            e.cyc = cyc;
            e.lat_chk = expect_lat2;
            sb.push_back(e);
        end else begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("drain", sb.size(), 64'd0);
    endtask

    // Main scoreboard: retiring beats are compared against the front of the queue.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_out", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("prod", out_prod, e.prod);
                checkOutput("out_exact", out_exact, e.ex);
                if (e.lat_chk) checkOutput("latency", cyc - e.cyc, 64'd2);
            end
        end
    end

    // Sweep scoreboard: only the selected instance may produce results.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sw_sb.delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (sw_ovld[k] && sw_ordy) begin
                    if (k != sw_sel || sw_sb.size() == 0) begin
                        checkOutput("sweep_spurious", 64'd1, 64'd0);
                    end else begin
                        e = sw_sb.pop_front();
                        checkOutput("sweep_prod", sw_prod[k], e.prod);
                        checkOutput("sweep_exact", sw_oex[k], e.ex);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        bit acc;
        beat_t e;
        errors = 0;
        checks = 0;
        cyc = 0;
        expect_lat2 = 1'b0;
        rst = 1'b1;
        in_valid = 1'b1;
        in_a = 7'd9;
        in_b = 7'd9;
        in_exact = 1'b1;
        out_ready = 1'b1;
        sw_valid = 1'b0;
        sw_ordy = 1'b1;
        sw_sel = 0;
        sw_a = '0;
        sw_b = '0;
        sw_ex = 1'b0;

        // Reset with in_valid held high: nothing may be accepted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 64'd0);
        checkOutput("rst_in_ready", in_ready, 64'd1);
        checkOutput("rst_out_prod", out_prod, 64'd0);
        checkOutput("rst_out_exact", out_exact, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_ignored_valid1", out_valid, 64'd0);
        @(negedge clk);
        checkOutput("rst_ignored_valid2", out_valid, 64'd0);
        @(posedge clk);
        #1;

        // Exact maximum operands with explicit two-cycle latency.
        expect_lat2 = 1'b1;
        applyStimulus(7'd127, 7'd127, 1'b1, 64'd16129);
        @(negedge clk);
        checkOutput("lat1_out_valid", out_valid, 64'd0);
        @(negedge clk);
        checkOutput("lat2_out_valid", out_valid, 64'd1);
        checkOutput("lat2_out_prod", out_prod, 64'd16129);
        @(posedge clk);
        #1;
        waitDrain();

        // Approximate mode directed values.
        applyStimulus(7'd127, 7'd127, 1'b0, 64'd16000);
        applyStimulus(7'd3, 7'd5, 1'b0, 64'd0);
        applyStimulus(7'd64, 7'd64, 1'b0, 64'd4096);
        waitDrain();

        // Backpressure: two beats fill the pipe, the third stalls until out_ready rises.
        expect_lat2 = 1'b0;
        out_ready = 1'b0;
        applyStimulus(7'd2, 7'd3, 1'b1, 64'd6);
        applyStimulus(7'd4, 7'd5, 1'b1, 64'd20);
        fork
            applyStimulus(7'd6, 7'd7, 1'b1, 64'd42);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", in_ready, 64'd0);
                    checkOutput("stall_out_valid", out_valid, 64'd1);
                    checkOutput("stall_out_prod", out_prod, 64'd6);
                    @(posedge clk);
                    #1;
                    in_a = 7'd99;
                    in_b = 7'd99;
                    in_exact = 1'b0;
                end
                in_a = 7'd6;
                in_b = 7'd7;
                in_exact = 1'b1;
                out_ready = 1'b1;
                @(negedge clk);
                checkOutput("bp_out0", out_prod, 64'd6);
                @(negedge clk);
                checkOutput("bp_out1_valid", out_valid, 64'd1);
                checkOutput("bp_out1", out_prod, 64'd20);
                @(negedge clk);
                checkOutput("bp_out2_valid", out_valid, 64'd1);
                checkOutput("bp_out2", out_prod, 64'd42);
            end
        join
        @(posedge clk);
        #1;
        waitDrain();

        // Full throughput: 100 random beats in 100 cycles.
        expect_lat2 = 1'b1;
        start_cyc = cyc;
        for (int n = 0; n < 100; n++) begin
            ra = 7'($urandom);
            rb = 7'($urandom);
            re = 1'($urandom);
            applyStimulus(ra, rb, re, model(7, 5, {57'd0, ra}, {57'd0, rb}, re));
        end
        checkOutput("throughput_cycles", cyc - start_cyc, 64'd100);
        waitDrain();

        // Reset with both stages full: in-flight beats are discarded.
        expect_lat2 = 1'b0;
        out_ready = 1'b0;
        applyStimulus(7'd10, 7'd10, 1'b1, 64'd100);
        applyStimulus(7'd3, 7'd3, 1'b1, 64'd9);
        @(negedge clk);
        checkOutput("pre_rst_in_ready", in_ready, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("midrst_out_valid", out_valid, 64'd0);
        checkOutput("midrst_in_ready", in_ready, 64'd1);
        checkOutput("midrst_out_prod", out_prod, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("no_stale", out_valid, 64'd0);
        end
        @(posedge clk);
        #1;

        // Parameter sweep with random backpressure.
        for (int s = 0; s < 4; s++) begin
            sw_sel = s;
            for (int n = 0; n < 40; n++) begin
                waited = 0;
                acc = 1'b0;
                sw_a = 16'($urandom);
                sw_b = 16'($urandom);
                sw_ex = 1'($urandom);
                sw_valid = 1'b1;
                while (!acc && waited < 60) begin
                    sw_ordy = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (sw_irdy[s]) begin
                        acc = 1'b1;
                        e.prod = model(SW_W[s], SW_T[s], {48'd0, sw_a}, {48'd0, sw_b}, sw_ex);
                        e.ex = sw_ex;
                        e.cyc = cyc;
                        e.lat_chk = 1'b0;
                        sw_sb.push_back(e);
                    end
                    @(posedge clk);
                    #1;
                    waited++;
                end
                if (!acc) checkOutput("sweep_accept", 64'd0, 64'd1);
            end
            sw_valid = 1'b0;
            sw_ordy = 1'b1;
            for (int k = 0; k < 50 && sw_sb.size() != 0; k++) @(posedge clk);
            #1;
            checkOutput("sweep_drain", sw_sb.size(), 64'd0);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
